// File: rtl/l1_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : l1_mem_arbiter_pkg
//  Description : Shared widths, arbiter state encodings and the round-robin
//                pick used by the L1 memory-port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package l1_mem_arbiter_pkg;

    localparam int c_DMEM_BLOCK_ADDR_SIZE = 16;
    localparam int c_DBLOCK_SIZE_BITS     = 128;

    // 3-bit arbiter state encodings
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_I_READ  = 3'd1,
        ST_D_READ  = 3'd2,
        ST_D_WRITE = 3'd3,
        ST_RELEASE = 3'd4
    } arbState_t;

    localparam logic [1:0] c_GRANT_NONE   = 2'b00;
    localparam logic [1:0] c_GRANT_ICACHE = 2'b01;
    localparam logic [1:0] c_GRANT_DCACHE = 2'b10;

    // Dcache wins when it is the only requester, or on a tie when the
    // previous grant went to the icache.
    function automatic logic pickDcache(input logic iReq, input logic dReq,
                                        input logic lastWasDcache);
        return dReq && (!iReq || !lastWasDcache);
    endfunction

endpackage
`default_nettype wire

// File: rtl/l1_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : l1_mem_arbiter
//  Description : Serialises icache refill reads and dcache refill/writeback
//                transactions onto a single main-memory block port and routes
//                the response back to the owner of the current grant.
//  Revision    : 1.0  initial release
// ============================================================================
module l1_mem_arbiter
    import l1_mem_arbiter_pkg::*;
#(
    parameter int BLOCK_ADDR_W = c_DMEM_BLOCK_ADDR_SIZE,
    parameter int BLOCK_W      = c_DBLOCK_SIZE_BITS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    iMemRen,
    input  logic [BLOCK_ADDR_W-1:0] iMemBlockAddr,
    output logic                    iMemReadReady,
    output logic [BLOCK_W-1:0]      iMemDout,
    input  logic                    dMemRen,
    input  logic                    dMemWen,
    input  logic [BLOCK_ADDR_W-1:0] dMemBlockAddr,
    input  logic [BLOCK_W-1:0]      dMemDin,
    output logic                    dMemReadReady,
    output logic                    dMemWriteDone,
    output logic [BLOCK_W-1:0]      dMemDout,
    output logic                    memRen,
    output logic                    memWen,
    output logic [BLOCK_ADDR_W-1:0] memBlockAddr,
    output logic [BLOCK_W-1:0]      memDin,
    input  logic                    memReadReady,
    input  logic                    memWriteDone,
    input  logic [BLOCK_W-1:0]      memDout,
    output logic [1:0]              grant
);

    arbState_t r_state;
    arbState_t w_nextState;
    logic      r_lastWasDcache;
    logic      w_iReq;
    logic      w_dReq;
    logic      w_winD;

    // A dcache write and read together is illegal; the write takes priority.
    assign w_iReq = iMemRen;
    assign w_dReq = dMemWen | dMemRen;
    assign w_winD = pickDcache(w_iReq, w_dReq, r_lastWasDcache);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: requests are only looked at in IDLE, so the requester just
    // served is naturally masked while RELEASE waits for memory to go quiet.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_iReq || w_dReq) begin
                    if (w_winD) begin
                        w_nextState = dMemWen ? ST_D_WRITE : ST_D_READ;
                    end else begin
                        w_nextState = ST_I_READ;
                    end
                end
            end
            ST_I_READ, ST_D_READ: begin
                if (memReadReady) w_nextState = ST_RELEASE;
            end
            ST_D_WRITE: begin
                if (memWriteDone) w_nextState = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!memReadReady && !memWriteDone) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Strobes and debug grant are decoded from the registered state only.
    always_comb begin
        memRen = 1'b0;
        memWen = 1'b0;
        grant  = c_GRANT_NONE;
        case (r_state)
            ST_I_READ: begin
                memRen = 1'b1;
                grant  = c_GRANT_ICACHE;
            end
            ST_D_READ: begin
                memRen = 1'b1;
                grant  = c_GRANT_DCACHE;
            end
            ST_D_WRITE: begin
                memWen = 1'b1;
                grant  = c_GRANT_DCACHE;
            end
            default: ;
        endcase
    end

    // Grant capture, response routing and one-cycle completion pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lastWasDcache <= 1'b0;
            memBlockAddr    <= '0;
            memDin          <= '0;
            iMemDout        <= '0;
            dMemDout        <= '0;
            iMemReadReady   <= 1'b0;
            dMemReadReady   <= 1'b0;
            dMemWriteDone   <= 1'b0;
        end else begin
            iMemReadReady <= 1'b0;
            dMemReadReady <= 1'b0;
            dMemWriteDone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_iReq || w_dReq) begin
                        r_lastWasDcache <= w_winD;
                        if (w_winD) begin
                            memBlockAddr <= dMemBlockAddr;
                            if (dMemWen) memDin <= dMemDin;
                        end else begin
                            memBlockAddr <= iMemBlockAddr;
                        end
                    end
                end
                ST_I_READ: begin
                    if (memReadReady) begin
                        iMemDout      <= memDout;
                        iMemReadReady <= 1'b1;
                    end
                end
                ST_D_READ: begin
                    if (memReadReady) begin
                        dMemDout      <= memDout;
                        dMemReadReady <= 1'b1;
                    end
                end
                ST_D_WRITE: begin
                    if (memWriteDone) dMemWriteDone <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l1_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l1_mem_arbiter
//  Description : Directed self-checking bench for l1_mem_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_l1_mem_arbiter;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         iMemRen = 1'b0;
    logic [15:0]  iMemBlockAddr = '0;
    logic         iMemReadReady;
    logic [127:0] iMemDout;
    logic         dMemRen = 1'b0;
    logic         dMemWen = 1'b0;
    logic [15:0]  dMemBlockAddr = '0;
    logic [127:0] dMemDin = '0;
    logic         dMemReadReady;
    logic         dMemWriteDone;
    logic [127:0] dMemDout;
    logic         memRen;
    logic         memWen;
    logic [15:0]  memBlockAddr;
    logic [127:0] memDin;
    logic         memReadReady = 1'b0;
    logic         memWriteDone = 1'b0;
    logic [127:0] memDout = '0;
    logic [1:0]   grant;

    int tests = 0;
    int fails = 0;

    l1_mem_arbiter #(.BLOCK_ADDR_W(16), .BLOCK_W(128)) dut (
        .clock(clock), .reset(reset),
        .iMemRen(iMemRen), .iMemBlockAddr(iMemBlockAddr),
        .iMemReadReady(iMemReadReady), .iMemDout(iMemDout),
        .dMemRen(dMemRen), .dMemWen(dMemWen), .dMemBlockAddr(dMemBlockAddr),
        .dMemDin(dMemDin), .dMemReadReady(dMemReadReady),
        .dMemWriteDone(dMemWriteDone), .dMemDout(dMemDout),
        .memRen(memRen), .memWen(memWen), .memBlockAddr(memBlockAddr),
        .memDin(memDin), .memReadReady(memReadReady),
        .memWriteDone(memWriteDone), .memDout(memDout), .grant(grant)
    );

    always #5 clock = ~clock;

    // Advance one cycle and settle past the active edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        iMemRen = 1'b0; dMemRen = 1'b0; dMemWen = 1'b0;
        memReadReady = 1'b0; memWriteDone = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tests++;
        if ({memRen, memWen, grant} !== 4'b0000) begin
            fails++; $display("FAIL reset_strobes: got %b expected 0000", {memRen, memWen, grant});
        end
        tests++;
        if ({iMemReadReady, dMemReadReady, dMemWriteDone} !== 3'b000) begin
            fails++; $display("FAIL reset_pulses: got %b expected 000", {iMemReadReady, dMemReadReady, dMemWriteDone});
        end
        tests++;
        if (iMemDout !== '0 || dMemDout !== '0 || memDin !== '0 || memBlockAddr !== '0) begin
            fails++; $display("FAIL reset_data: iDout=%h dDout=%h memDin=%h addr=%h expected 0", iMemDout, dMemDout, memDin, memBlockAddr);
        end
        reset = 1'b1;
    endtask

    task automatic test_lone_iread();
        logic [127:0] pat;
        int           lowSeen;
        pat = 128'hAA << 120;
        lowSeen = 0;
        iMemRen = 1'b1; iMemBlockAddr = 16'h0041;
        tick();
        tests++;
        if (memRen !== 1'b1 || grant !== 2'b01 || memBlockAddr !== 16'h0041) begin
            fails++; $display("FAIL iread_grant: memRen=%b grant=%b addr=%h expected 1 01 0041", memRen, grant, memBlockAddr);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            if (memRen !== 1'b1 || iMemReadReady !== 1'b0) lowSeen++;
        end
        tests++;
        if (lowSeen !== 0) begin
            fails++; $display("FAIL iread_hold: got %0d bad cycles expected 0", lowSeen);
        end
        memReadReady = 1'b1; memDout = pat;
        tick();
        tests++;
        if (iMemReadReady !== 1'b1 || iMemDout !== pat || memRen !== 1'b0) begin
            fails++; $display("FAIL iread_done: pulse=%b dout=%h memRen=%b expected 1 %h 0", iMemReadReady, iMemDout, memRen, pat);
        end
        iMemRen = 1'b0; memReadReady = 1'b0;
        tick();
        tests++;
        if (iMemReadReady !== 1'b0 || grant !== 2'b00 || iMemDout !== pat) begin
            fails++; $display("FAIL iread_release: pulse=%b grant=%b dout=%h expected 0 00 %h", iMemReadReady, grant, iMemDout, pat);
        end
    endtask

    // Four consecutive ties from reset: dcache, icache, dcache, icache.
    task automatic test_tie_alternate();
        logic [127:0] pat;
        logic         winD;
        doReset();
        iMemRen = 1'b1; iMemBlockAddr = 16'h0010;
        dMemRen = 1'b1; dMemBlockAddr = 16'h00F0;
        for (int k = 0; k < 4; k++) begin
            winD = (k % 2 == 0);
            pat  = {4{32'hC0DE0000 + 32'(k)}};
            tick();
            tests++;
            if (grant !== (winD ? 2'b10 : 2'b01) || memBlockAddr !== (winD ? 16'h00F0 : 16'h0010)) begin
                fails++; $display("FAIL tie%0d_grant: grant=%b addr=%h expected %b %h", k, grant, memBlockAddr,
                                  winD ? 2'b10 : 2'b01, winD ? 16'h00F0 : 16'h0010);
            end
            memReadReady = 1'b1; memDout = pat;
            tick();
            tests++;
            if ({iMemReadReady, dMemReadReady} !== (winD ? 2'b01 : 2'b10) ||
                (winD ? dMemDout : iMemDout) !== pat) begin
                fails++; $display("FAIL tie%0d_done: pulses=%b dout=%h expected %b %h", k, {iMemReadReady, dMemReadReady},
                                  winD ? dMemDout : iMemDout, winD ? 2'b01 : 2'b10, pat);
            end
            memReadReady = 1'b0;
            if (winD) dMemRen = 1'b0; else iMemRen = 1'b0;
            tick();
            tests++;
            if (grant !== 2'b00) begin
                fails++; $display("FAIL tie%0d_idle: grant=%b expected 00", k, grant);
            end
            if (winD) dMemRen = 1'b1; else iMemRen = 1'b1;
        end
        iMemRen = 1'b0; dMemRen = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        dMemWen = 1'b1; dMemBlockAddr = 16'h0ABC; dMemDin = {4{32'h5A5A5A5A}};
        tick();
        tests++;
        if (memWen !== 1'b1 || grant !== 2'b10) begin
            fails++; $display("FAIL midrst_pre: memWen=%b grant=%b expected 1 10", memWen, grant);
        end
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({memWen, memRen, grant, iMemReadReady, dMemReadReady, dMemWriteDone} !== 7'b0) begin
            fails++; $display("FAIL midrst_ctrl: got %b expected 0000000",
                              {memWen, memRen, grant, iMemReadReady, dMemReadReady, dMemWriteDone});
        end
        tests++;
        if (dMemDout !== '0 || memDin !== '0) begin
            fails++; $display("FAIL midrst_data: dDout=%h memDin=%h expected 0", dMemDout, memDin);
        end
        dMemWen = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [127:0] pat;
        pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        doReset();
        dMemWen = 1'b1; dMemBlockAddr = 16'h0F12; dMemDin = '1;
        iMemRen = 1'b1; iMemBlockAddr = 16'h0333;
        tick();
        tests++;
        if (memWen !== 1'b1 || memRen !== 1'b0 || memDin !== {128{1'b1}} || memBlockAddr !== 16'h0F12) begin
            fails++; $display("FAIL wb_grant: memWen=%b memRen=%b memDin=%h addr=%h expected 1 0 all-ones 0f12",
                              memWen, memRen, memDin, memBlockAddr);
        end
        memReadReady = 1'b1;
        repeat (2) tick();
        tests++;
        if (memWen !== 1'b1 || {iMemReadReady, dMemReadReady, dMemWriteDone} !== 3'b000) begin
            fails++; $display("FAIL wb_stray_rr: memWen=%b pulses=%b expected 1 000", memWen,
                              {iMemReadReady, dMemReadReady, dMemWriteDone});
        end
        memReadReady = 1'b0; memWriteDone = 1'b1;
        tick();
        tests++;
        if (dMemWriteDone !== 1'b1 || memWen !== 1'b0) begin
            fails++; $display("FAIL wb_done: pulse=%b memWen=%b expected 1 0", dMemWriteDone, memWen);
        end
        dMemWen = 1'b0; dMemRen = 1'b1; memWriteDone = 1'b0;
        tick();
        tests++;
        if (dMemWriteDone !== 1'b0 || grant !== 2'b00) begin
            fails++; $display("FAIL wb_release: pulse=%b grant=%b expected 0 00", dMemWriteDone, grant);
        end
        tick();
        tests++;
        if (grant !== 2'b01 || memBlockAddr !== 16'h0333 || memRen !== 1'b1) begin
            fails++; $display("FAIL wb_next: grant=%b addr=%h memRen=%b expected 01 0333 1", grant, memBlockAddr, memRen);
        end
        memReadReady = 1'b1; memDout = pat;
        tick();
        tests++;
        if (iMemReadReady !== 1'b1 || iMemDout !== pat || dMemReadReady !== 1'b0) begin
            fails++; $display("FAIL wb_iread: ipulse=%b dout=%h dpulse=%b expected 1 %h 0", iMemReadReady, iMemDout, dMemReadReady, pat);
        end
        iMemRen = 1'b0; dMemRen = 1'b0; memReadReady = 1'b0;
        tick();
    endtask

    task automatic test_stray();
        logic [127:0] pat;
        int           pulses;
        int           badGrant;
        pat = 128'h1234;
        pulses = 0;
        badGrant = 0;
        memReadReady = 1'b1;
        repeat (2) tick();
        tests++;
        if ({iMemReadReady, dMemReadReady, dMemWriteDone} !== 3'b000 || grant !== 2'b00) begin
            fails++; $display("FAIL stray_idle: pulses=%b grant=%b expected 000 00",
                              {iMemReadReady, dMemReadReady, dMemWriteDone}, grant);
        end
        memReadReady = 1'b0;
        iMemRen = 1'b1; iMemBlockAddr = 16'h0055;
        tick();
        memWriteDone = 1'b1;
        tick();
        tests++;
        if (iMemReadReady !== 1'b0 || memRen !== 1'b1 || grant !== 2'b01) begin
            fails++; $display("FAIL stray_wd: pulse=%b memRen=%b grant=%b expected 0 1 01", iMemReadReady, memRen, grant);
        end
        memWriteDone = 1'b0;
        memReadReady = 1'b1; memDout = pat;
        tick();
        if (iMemReadReady === 1'b1) pulses++;
        iMemRen = 1'b0;
        tick();
        if (iMemReadReady === 1'b1) pulses++;
        iMemRen = 1'b1; iMemBlockAddr = 16'h0066;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (iMemReadReady === 1'b1) pulses++;
            if (grant !== 2'b00 || memRen !== 1'b0) badGrant++;
        end
        tests++;
        if (pulses !== 1) begin
            fails++; $display("FAIL stray_pulses: got %0d expected 1", pulses);
        end
        tests++;
        if (badGrant !== 0 || iMemDout !== pat) begin
            fails++; $display("FAIL stray_hold: bad=%0d dout=%h expected 0 %h", badGrant, iMemDout, pat);
        end
        memReadReady = 1'b0;
        tick();
        tests++;
        if (grant !== 2'b00) begin
            fails++; $display("FAIL stray_exit: grant=%b expected 00", grant);
        end
        tick();
        tests++;
        if (grant !== 2'b01 || memBlockAddr !== 16'h0066) begin
            fails++; $display("FAIL stray_regrant: grant=%b addr=%h expected 01 0066", grant, memBlockAddr);
        end
        memReadReady = 1'b1; memDout = '0;
        tick();
        iMemRen = 1'b0; memReadReady = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_lone_iread();
        test_tie_alternate();
        test_reset_mid();
        test_back_to_back();
        test_stray();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
